nice_seq_reader: RTL and testbench

Hardware iterator for a sequential container: on `start_i` it walks indices 0..size-1 of an index-addressed store and streams each element out, in order, on a valid/ready port, flagging the final element. It is the read-side counterpart to the team's sequential-container writers. The store is reached through an indexed request/response port. Up to two reads are in flight, and a 2-entry output FIFO keeps full throughput under backpressure.

---
 rtl/nice_seq_reader.sv | 193 +++++++++++++++++++
 tb/tb_nice_seq_reader.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nice_seq_reader.sv
// nice_seq_reader: walks indices 0..size-1 of an indexed store and streams
// each element out on a valid/ready port, flagging the final element.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start_i, size_i   begin iteration of size_i elements (saturated to 2^IDX_W)
//   abort_i           cancel the running iteration
//   rd_req_o/idx_o    read request to the store, accepted with rd_gnt_i
//   rd_rvalid_i/data  in-order read responses
//   out_*             element stream (data, index, last flag)
//   busy_o, done_o    not-idle status, one-cycle completion pulse
//   err_o             sticky flag for unsolicited read responses
module nice_seq_reader #(
    parameter int DATA_W = 32,
    parameter int IDX_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [IDX_W:0]    size_i,
    input  logic              abort_i,
    output logic              rd_req_o,
    output logic [IDX_W-1:0]  rd_idx_o,
    input  logic              rd_gnt_i,
    input  logic              rd_rvalid_i,
    input  logic [DATA_W-1:0] rd_rdata_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic [IDX_W-1:0]  out_idx_o,
    output logic              out_last_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o
);

    localparam int CW = IDX_W + 1;
    localparam logic [CW-1:0] MAX_SIZE = {1'b1, {IDX_W{1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        FLUSH
    } state_e;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [IDX_W-1:0]  idx;
        logic              last;
    } elem_t;

    state_e          state_q, state_d;
    logic [CW-1:0]   size_q, size_d;
    logic [CW-1:0]   req_cnt_q, req_cnt_d;
    logic [CW-1:0]   rsp_cnt_q, rsp_cnt_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    // Set by the first accepted start; responses that arrive after a reset
    // belong to a cancelled iteration and must not raise the error flag.
    logic            armed_q, armed_d;
    logic [1:0]      fifo_cnt_q, fifo_cnt_d;
    logic            wr_ptr_q, wr_ptr_d;
    logic            rd_ptr_q, rd_ptr_d;
    elem_t           mem_q [2];

    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   inflight;
    logic [CW-1:0]   size_sat;
    logic [1:0]      fifo_cnt_nxt;
    logic            active;
    logic            pop;
    logic            gnt;
    logic            rsp_ok;
    logic            push;
    logic            fifo_clr;
    elem_t           head;

    assign outstanding = req_cnt_q - rsp_cnt_q;
    assign out_valid_o = (fifo_cnt_q != 2'd0);
    assign pop         = out_valid_o & out_ready_i;
    // Credit counts the FIFO after this cycle's pop, so a draining consumer
    // frees a slot immediately and streaming runs at one element per cycle.
    assign inflight    = outstanding + CW'(fifo_cnt_q) - CW'(pop);
    assign size_sat    = (size_i > MAX_SIZE) ? MAX_SIZE : size_i;
    assign active      = (state_q == ISSUE) || (state_q == DRAIN);
    assign rd_req_o    = (state_q == ISSUE) && (inflight < CW'(2));
    assign rd_idx_o    = rd_req_o ? req_cnt_q[IDX_W-1:0] : '0;
    assign gnt         = rd_req_o & rd_gnt_i;
    assign rsp_ok      = rd_rvalid_i && (outstanding != '0);
    assign push        = rsp_ok && active && !abort_i;

    assign fifo_cnt_nxt = fifo_cnt_q + 2'(push) - 2'(pop);

    assign head        = mem_q[rd_ptr_q];
    assign out_data_o  = out_valid_o ? head.data : '0;
    assign out_idx_o   = out_valid_o ? head.idx : '0;
    assign out_last_o  = out_valid_o & head.last;
    assign busy_o      = (state_q != IDLE);
    assign done_o      = done_q;
    assign err_o       = err_q;

    always_comb begin
        state_d   = state_q;
        size_d    = size_q;
        req_cnt_d = req_cnt_q + CW'(gnt);
        rsp_cnt_d = rsp_cnt_q + CW'(rsp_ok);
        done_d    = 1'b0;
        err_d     = err_q | (rd_rvalid_i && (outstanding == '0) && armed_q);
        armed_d   = armed_q;
        fifo_clr  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    size_d    = size_sat;
                    err_d     = 1'b0;
                    armed_d   = 1'b1;
                    req_cnt_d = '0;
                    rsp_cnt_d = '0;
                    fifo_clr  = 1'b1;
                    if (size_sat == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (abort_i) begin
                    state_d  = FLUSH;
                    fifo_clr = 1'b1;
                end else if (req_cnt_d == size_q) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (abort_i) begin
                    state_d  = FLUSH;
                    fifo_clr = 1'b1;
                end else if (rsp_cnt_d == size_q && fifo_cnt_nxt == 2'd0) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            FLUSH: begin
                if (rsp_cnt_d == req_cnt_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        fifo_cnt_d = fifo_clr ? 2'd0 : fifo_cnt_nxt;
        wr_ptr_d   = fifo_clr ? 1'b0 : (wr_ptr_q ^ push);
        rd_ptr_d   = fifo_clr ? 1'b0 : (rd_ptr_q ^ pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            size_q     <= '0;
            req_cnt_q  <= '0;
            rsp_cnt_q  <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            armed_q    <= 1'b0;
            fifo_cnt_q <= 2'd0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            size_q     <= size_d;
            req_cnt_q  <= req_cnt_d;
            rsp_cnt_q  <= rsp_cnt_d;
            done_q     <= done_d;
            err_q      <= err_d;
            armed_q    <= armed_d;
            fifo_cnt_q <= fifo_cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= '{
                data: rd_rdata_i,
                idx:  rsp_cnt_q[IDX_W-1:0],
                last: (rsp_cnt_q == size_q - CW'(1))
            };
        end
    end

endmodule

// File: tb/tb_nice_seq_reader.sv
// Testbench for nice_seq_reader: randomized store responder, scoreboard
// of expected elements, and an independent output monitor.
module tb_nice_seq_reader;

    localparam int DW = 32;
    localparam int IW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start_i = 1'b0;
    logic [IW:0]   size_i = '0;
    logic          abort_i = 1'b0;
    logic          rd_req_o;
    logic [IW-1:0] rd_idx_o;
    logic          rd_gnt_i = 1'b0;
    logic          rd_rvalid_i = 1'b0;
    logic [DW-1:0] rd_rdata_i = '0;
    logic          out_valid_o;
    logic          out_ready_i = 1'b0;
    logic [DW-1:0] out_data_o;
    logic [IW-1:0] out_idx_o;
    logic          out_last_o;
    logic          busy_o;
    logic          done_o;
    logic          err_o;

    nice_seq_reader #(.DATA_W(DW), .IDX_W(IW)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .size_i(size_i),
        .abort_i(abort_i), .rd_req_o(rd_req_o), .rd_idx_o(rd_idx_o),
        .rd_gnt_i(rd_gnt_i), .rd_rvalid_i(rd_rvalid_i),
        .rd_rdata_i(rd_rdata_i), .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i), .out_data_o(out_data_o),
        .out_idx_o(out_idx_o), .out_last_o(out_last_o),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int idx;
        int due;
    } rsp_t;

    rsp_t          pend[$];
    logic [40:0]   exp_q[$];
    int            n_vec = 0;
    int            n_err = 0;
    int            gnt_pct = 100;
    int            rdy_pct = 100;
    int            lat = 1;
    bit            force_rdy0 = 0;
    bit            stray = 0;
    logic [31:0]   base = 0;
    logic [31:0]   stride = 1;
    int            n_gnt = 0;
    int            n_hs = 0;
    int            n_done = 0;
    int            first_hs = -1;
    int            last_hs = -100;
    int            zero_cyc = -100;
    int            exp_req = 0;
    int            last_due = 0;

    function automatic logic [31:0] store(int i);
        return base + stride * 32'(i);
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Store model: grants, in-order responses after lat cycles, strays.
    initial begin
        int due;
        forever begin
            @(posedge clk);
            #1;
            rd_gnt_i = ($urandom_range(99) < gnt_pct);
            out_ready_i = !force_rdy0 && ($urandom_range(99) < rdy_pct);
            if (pend.size() > 0 && pend[0].due <= cyc) begin
                rd_rvalid_i = 1'b1;
                rd_rdata_i = store(pend[0].idx);
                void'(pend.pop_front());
            end else if (stray) begin
                rd_rvalid_i = 1'b1;
                rd_rdata_i = 32'hdeadbeef;
                stray = 0;
            end else begin
                rd_rvalid_i = 1'b0;
                rd_rdata_i = '0;
            end
            @(negedge clk);
            if (rd_req_o && rd_gnt_i) begin
                chk("rd_idx", 64'(rd_idx_o), 64'(exp_req[7:0]));
                due = cyc + lat;
                if (due <= last_due) due = last_due + 1;
                pend.push_back('{idx: exp_req, due: due});
                last_due = due;
                exp_req++;
                n_gnt++;
            end
        end
    end

    // Output monitor: pops the scoreboard on every handshake.
    initial begin
        logic [40:0] e;
        forever begin
            @(negedge clk);
            if (out_valid_o && out_ready_i) begin
                n_hs++;
                if (first_hs < 0) first_hs = cyc;
                last_hs = cyc;
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_out: got idx %0d data %08h, required none",
                             out_idx_o, out_data_o);
                end else begin
                    e = exp_q.pop_front();
                    chk("out", 64'({out_data_o, out_idx_o, out_last_o}), 64'(e));
                end
            end
            if (done_o) begin
                n_done++;
                chk("done_busy", 64'(busy_o), 0);
                chk("done_timing",
                    64'((last_hs == cyc - 1) || (zero_cyc == cyc - 1)), 1);
            end
        end
    end

    task automatic do_start(int sz);
        int s;
        s = (sz > 256) ? 256 : sz;
        exp_req = 0;
        first_hs = -1;
        n_hs = 0;
        for (int i = 0; i < s; i++) begin
            exp_q.push_back({store(i), 8'(i), 1'(i == s - 1)});
        end
        if (s == 0) zero_cyc = cyc;
        start_i = 1'b1;
        size_i = 9'(sz);
        step();
        start_i = 1'b0;
    endtask

    task automatic wait_idle(int budget);
        bit ok;
        ok = 0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (!busy_o) begin
                ok = 1;
                break;
            end
        end
        n_vec++;
        if (!ok) begin
            n_err++;
            $display("FAIL idle_timeout: busy 1 after %0d cycles, required 0", budget);
        end
        step();
    endtask

    task automatic run(int sz);
        int d0;
        d0 = n_done;
        do_start(sz);
        wait_idle(6000);
        chk("drained", 64'(exp_q.size()), 0);
        chk("done_cnt", 64'(n_done - d0), 1);
    endtask

    initial begin
        int d0;
        int g0;
        bit ok;

        repeat (3) step();
        chk("rst_req", 64'(rd_req_o), 0);
        chk("rst_idx", 64'(rd_idx_o), 0);
        chk("rst_valid", 64'(out_valid_o), 0);
        chk("rst_data", 64'(out_data_o), 0);
        chk("rst_oidx", 64'(out_idx_o), 0);
        chk("rst_last", 64'(out_last_o), 0);
        chk("rst_busy", 64'(busy_o), 0);
        chk("rst_done", 64'(done_o), 0);
        chk("rst_err", 64'(err_o), 0);
        rst = 1'b0;
        step();

        // size 4, latency 1, full rate
        base = 32'h100;
        stride = 1;
        d0 = n_done;
        do_start(4);
        chk("t1_busy", 64'(busy_o), 1);
        chk("t1_req", 64'(rd_req_o), 1);
        chk("t1_idx0", 64'(rd_idx_o), 0);
        wait_idle(100);
        chk("t1_drained", 64'(exp_q.size()), 0);
        chk("t1_rate", 64'(last_hs - first_hs), 3);
        chk("t1_done", 64'(n_done - d0), 1);

        // size 0
        do_start(0);
        chk("t2_done", 64'(done_o), 1);
        chk("t2_busy", 64'(busy_o), 0);
        chk("t2_req", 64'(rd_req_o), 0);
        chk("t2_valid", 64'(out_valid_o), 0);
        step();
        chk("t2_pulse", 64'(done_o), 0);

        // backpressure
        base = 32'h2000;
        stride = 7;
        force_rdy0 = 1;
        g0 = n_gnt;
        d0 = n_done;
        do_start(8);
        repeat (10) step();
        chk("bp_grants", 64'((n_gnt - g0) <= 2), 1);
        chk("bp_valid", 64'(out_valid_o), 1);
        chk("bp_none", 64'(n_hs), 0);
        force_rdy0 = 0;
        wait_idle(200);
        chk("bp_all", 64'(n_hs), 8);
        chk("bp_done", 64'(n_done - d0), 1);

        // abort after 5 outputs, latency 3
        base = 32'h3000;
        stride = 1;
        lat = 3;
        d0 = n_done;
        do_start(16);
        ok = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (n_hs >= 5) begin
                ok = 1;
                break;
            end
        end
        chk("ab_reach5", 64'(ok), 1);
        step();
        abort_i = 1'b1;
        step();
        abort_i = 1'b0;
        exp_q.delete();
        chk("ab_valid", 64'(out_valid_o), 0);
        chk("ab_req", 64'(rd_req_o), 0);
        wait_idle(100);
        chk("ab_nodone", 64'(n_done - d0), 0);
        chk("ab_partial", 64'(n_hs < 16), 1);
        chk("ab_pend", 64'(pend.size()), 0);
        lat = 1;
        run(2);
        chk("ab_restart", 64'(n_hs), 2);

        // unsolicited response in IDLE
        @(negedge clk);
        stray = 1;
        step();
        step();
        chk("err_set", 64'(err_o), 1);
        repeat (4) step();
        chk("err_sticky", 64'(err_o), 1);
        do_start(1);
        chk("err_clr", 64'(err_o), 0);
        wait_idle(100);

        // saturated size
        base = 32'h5000;
        stride = 3;
        lat = 2;
        gnt_pct = 70;
        rdy_pct = 70;
        run(256 + 5);
        chk("sat_cnt", 64'(n_hs), 256);

        // random iterations
        for (int r = 0; r < 8; r++) begin
            base = $urandom;
            stride = $urandom | 32'd1;
            lat = int'($urandom_range(3, 1));
            gnt_pct = int'($urandom_range(100, 40));
            rdy_pct = int'($urandom_range(100, 40));
            run(int'($urandom_range(20, 0)));
        end

        // reset mid-iteration
        lat = 3;
        gnt_pct = 100;
        rdy_pct = 100;
        do_start(20);
        repeat (6) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_q.delete();
        chk("mr_busy", 64'(busy_o), 0);
        chk("mr_valid", 64'(out_valid_o), 0);
        chk("mr_req", 64'(rd_req_o), 0);
        chk("mr_err", 64'(err_o), 0);
        for (int k = 0; k < 50 && pend.size() != 0; k++) step();
        step();
        chk("mr_err_after", 64'(err_o), 0);
        chk("mr_valid_after", 64'(out_valid_o), 0);
        lat = 1;
        run(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
